// File: rtl/dcache_pkg.sv
// Shared types, widths and helpers for the direct-mapped write-back data cache.
// Pure declarations: no logic, no latency.
package dcache_pkg;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int BLOCK_W  = 128;
  localparam int OFFSET_W = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_t;

  // Latched CPU request; the byte-lane bits of the address are dropped.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W-1:2]     addr;
    logic [WORD_W-1:0]     wdata;
  } req_t;

  // Word i of a block lives at bits [32i+31:32i].
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                  input logic [OFFSET_W-1:0] off);
    word_sel = blk[{off, 5'b00000} +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous block fill or word write.
// Valid and dirty bits reset; tag and data arrays hold whatever they last received.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES   = 16,
  parameter int INDEX_W = $clog2(LINES),
  parameter int TAG_W   = ADDR_W - 4 - INDEX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  index,
  output logic                valid,
  output logic                dirty,
  output logic [TAG_W-1:0]    tag,
  output logic [BLOCK_W-1:0]  data,
  input  logic                fill_en,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data,
  input  logic                word_en,
  input  logic [OFFSET_W-1:0] word_off,
  input  logic [WORD_W-1:0]   word_data
);

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [BLOCK_W-1:0] data_mem [LINES];

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_mem[index];
  assign data  = data_mem[index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_en) begin
      dirty_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[index]  <= fill_tag;
      data_mem[index] <= fill_data;
    end else if (word_en) begin
      data_mem[index][{word_off, 5'b00000} +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller; hit acks one cycle after sampling.
// CPU is stalled through misses; memory requests are held with no timeout until mem_ack_i.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cpu_req_i,
  input  logic               cpu_we_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  input  logic [WORD_W-1:0]  cpu_wdata_i,
  output logic [WORD_W-1:0]  cpu_rdata_o,
  output logic               cpu_ack_o,
  output logic               cpu_stall_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BLOCK_W-1:0] mem_wdata_o,
  input  logic [BLOCK_W-1:0] mem_rdata_i,
  input  logic               mem_ack_i,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o,
  output logic [31:0]        wb_cnt_o
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - 4 - INDEX_W;

  state_t state, state_nxt;
  req_t   req_q;
  logic   recompare;

  logic [OFFSET_W-1:0] req_off;
  logic [INDEX_W-1:0]  req_index;
  logic [TAG_W-1:0]    req_tag;

  logic               line_valid, line_dirty, hit;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_data;
  logic               fill_en, word_en;

  // Byte-lane bits are don't-care for word accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign req_off   = req_q.addr[3:2];
  assign req_index = req_q.addr[4 +: INDEX_W];
  assign req_tag   = req_q.addr[ADDR_W-1 -: TAG_W];
  assign hit       = line_valid && (line_tag == req_tag);

  dcache_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk       (clk_i),
    .rst       (rst_i),
    .index     (req_index),
    .valid     (line_valid),
    .dirty     (line_dirty),
    .tag       (line_tag),
    .data      (line_data),
    .fill_en   (fill_en),
    .fill_tag  (req_tag),
    .fill_data (mem_rdata_i),
    .word_en   (word_en),
    .word_off  (req_off),
    .word_data (req_q.wdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cpu_ack_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    fill_en     = 1'b0;
    word_en     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req_i) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_ack_o = 1'b1;
          word_en   = req_q.we;
          state_nxt = IDLE;
        end else if (line_valid && line_dirty) begin
          state_nxt = WRITE_BACK;
        end else begin
          state_nxt = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {line_tag, req_index, 4'b0000};
        mem_wdata_o = line_data;
        if (mem_ack_i) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag, req_index, 4'b0000};
        if (mem_ack_i) begin
          fill_en   = 1'b1;
          state_nxt = COMPARE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A reset edge abandons any in-flight line update.
    if (rst_i) begin
      fill_en = 1'b0;
      word_en = 1'b0;
    end
  end

  assign cpu_stall_o = (state != IDLE) && !cpu_ack_o;
  assign cpu_rdata_o = (cpu_ack_o && !req_q.we) ? word_sel(line_data, req_off) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q <= '0;
    end else if (state == IDLE && cpu_req_i) begin
      req_q.we    <= cpu_we_i;
      req_q.addr  <= cpu_addr_i[ADDR_W-1:2];
      req_q.wdata <= cpu_wdata_i;
    end
  end

  // Marks the compare that follows a fill so it is not counted a second time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      recompare <= 1'b0;
    end else if (state == ALLOCATE && mem_ack_i) begin
      recompare <= 1'b1;
    end else if (state == IDLE) begin
      recompare <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      if (state == COMPARE && hit && !recompare)  hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (state == COMPARE && !hit && !recompare) miss_cnt_o <= miss_cnt_o + 32'd1;
      if (state == WRITE_BACK && mem_ack_i)       wb_cnt_o   <= wb_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a line-level cache model and a block memory model.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, cpu_req, cpu_we, cpu_ack, cpu_stall, mem_req, mem_we, mem_ack;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata, mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [31:0]  hit_cnt, miss_cnt, wb_cnt;

  dcache_ctrl #(.LINES(16)) dut (
    .clk_i(clk), .rst_i(rst), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
    .cpu_ack_o(cpu_ack), .cpu_stall_o(cpu_stall), .mem_req_o(mem_req),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .hit_cnt_o(hit_cnt),
    .miss_cnt_o(miss_cnt), .wb_cnt_o(wb_cnt)
  );

  localparam logic [127:0] BASE = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  int checks = 0;
  int errors = 0;

  // Reference model: cache lines, backing memory of blocks, event counts.
  bit           m_valid [16];
  bit           m_dirty [16];
  logic [23:0]  m_tag   [16];
  logic [127:0] m_data  [16];
  logic [127:0] mem     [logic [31:0]];
  logic [31:0]  m_hit, m_miss, m_wb;
  bit           rnd_mode;

  logic         e_ack, e_stall, e_req, e_we, e_acare, e_wcare, e_rcare;
  logic [31:0]  e_addr, e_rdata;
  logic [127:0] e_wdata;
  bit           chk_en;

  logic [31:0]  last_rdata, last_wb_addr, last_fill_addr;
  logic [127:0] last_wb_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_ack", cpu_ack, e_ack);
      chk("cpu_stall", cpu_stall, e_stall);
      chk("mem_req", mem_req, e_req);
      chk("mem_we", mem_we, e_we);
      if (e_acare) chk("mem_addr", mem_addr, e_addr);
      if (e_wcare) chk("mem_wdata", mem_wdata, e_wdata);
      if (e_rcare) chk("cpu_rdata", cpu_rdata, e_rdata);
      chk("hit_cnt", hit_cnt, m_hit);
      chk("miss_cnt", miss_cnt, m_miss);
      chk("wb_cnt", wb_cnt, m_wb);
      if (cpu_ack) last_rdata = cpu_rdata;
      if (mem_req && mem_we) begin
        last_wb_addr = mem_addr;
        last_wb_data = mem_wdata;
      end
      if (mem_req && !mem_we) last_fill_addr = mem_addr;
    end
  end

  task automatic set_exp(input logic ack, input logic stall, input logic req, input logic we,
                         input logic [31:0] addr, input logic acare, input logic [127:0] wd,
                         input logic wcare, input logic [31:0] rd, input logic rcare);
    e_ack = ack; e_stall = stall; e_req = req; e_we = we;
    e_addr = addr; e_acare = acare; e_wdata = wd; e_wcare = wcare;
    e_rdata = rd; e_rcare = rcare;
  endtask

  task automatic idle_exp();
    set_exp(0, 0, 0, 0, 32'h0, 0, 128'h0, 0, 32'h0, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic stray();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic logic [127:0] get_block(input logic [31:0] ba);
    if (!mem.exists(ba)) mem[ba] = rnd_mode ? rand128() : BASE;
    return mem[ba];
  endfunction

  // CPU inputs are don't-care (and requests ignored) while the cache is busy.
  task automatic busy();
    cpu_req   = 1'($urandom_range(0, 1));
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_hit = 0; m_miss = 0; m_wb = 0;
  endtask

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd, input int d);
    logic [3:0]   idx;
    logic [23:0]  tg;
    logic [1:0]   off;
    logic         hit, wb;
    logic [31:0]  ba, oba;
    logic [127:0] blk;
    idx = a[7:4]; tg = a[31:8]; off = a[3:2]; ba = {a[31:4], 4'b0000};
    hit = m_valid[idx] && (m_tag[idx] == tg);
    wb  = !hit && m_valid[idx] && m_dirty[idx];
    oba = {m_tag[idx], idx, 4'b0000};
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    mem_ack = stray(); mem_rdata = rand128();
    idle_exp();
    step();
    if (!hit) begin
      busy(); mem_ack = stray();
      set_exp(0, 1, 0, 0, 32'h0, 0, 128'h0, 0, 32'h0, 1);
      step();
      m_miss++;
      if (wb) begin
        for (int k = 0; k <= d; k++) begin
          busy(); mem_ack = (k == d); mem_rdata = rand128();
          set_exp(0, 1, 1, 1, oba, 1, m_data[idx], 1, 32'h0, 1);
          step();
        end
        mem[oba] = m_data[idx];
        m_wb++;
      end
      blk = get_block(ba);
      for (int k = 0; k <= d; k++) begin
        busy(); mem_ack = (k == d); mem_rdata = (k == d) ? blk : rand128();
        set_exp(0, 1, 1, 0, ba, 1, 128'h0, 0, 32'h0, 1);
        step();
      end
      m_valid[idx] = 1; m_dirty[idx] = 0; m_tag[idx] = tg; m_data[idx] = blk;
    end
    busy(); mem_ack = stray(); mem_rdata = rand128();
    if (we) set_exp(1, 0, 0, 0, 32'h0, 0, 128'h0, 0, 32'h0, 0);
    else    set_exp(1, 0, 0, 0, 32'h0, 0, 128'h0, 0, m_data[idx][{off, 5'b00000} +: 32], 1);
    step();
    if (hit) m_hit++;
    if (we) begin
      m_data[idx][{off, 5'b00000} +: 32] = wd;
      m_dirty[idx] = 1;
    end
    cpu_req = 0; mem_ack = 0;
    idle_exp();
  endtask

  // Read miss to a clean/invalid line, with reset asserted partway through the fill.
  task automatic req_reset_in_alloc(input logic [31:0] a);
    logic [31:0] ba;
    ba = {a[31:4], 4'b0000};
    cpu_req = 1; cpu_we = 0; cpu_addr = a; cpu_wdata = 0; mem_ack = 0;
    idle_exp();
    step();
    busy();
    set_exp(0, 1, 0, 0, 32'h0, 0, 128'h0, 0, 32'h0, 1);
    step();
    m_miss++;
    busy();
    set_exp(0, 1, 1, 0, ba, 1, 128'h0, 0, 32'h0, 1);
    step();
    busy(); rst = 1;
    set_exp(0, 1, 1, 0, ba, 1, 128'h0, 0, 32'h0, 1);
    step();
    rst = 0; cpu_req = 0; mem_ack = 0;
    model_reset();
    set_exp(0, 0, 0, 0, 32'h0, 1, 128'h0, 1, 32'h0, 1);
    step();
    idle_exp();
  endtask

  initial begin
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    mem_ack = 0; mem_rdata = 0; chk_en = 0; rnd_mode = 0;
    last_rdata = 0; last_wb_addr = 0; last_fill_addr = 0; last_wb_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    set_exp(0, 0, 0, 0, 32'h0, 1, 128'h0, 1, 32'h0, 1);
    chk_en = 1;
    step();
    idle_exp();

    do_req(0, 32'h44, 32'h0, 2);
    chk("lit_fill_addr_40", last_fill_addr, 32'h40);
    chk("lit_rdata_44", last_rdata, 32'h2222_2222);
    chk("lit_miss_1", miss_cnt, 32'd1);

    do_req(0, 32'h48, 32'h0, 0);
    chk("lit_rdata_48", last_rdata, 32'h3333_3333);
    chk("lit_hit_1", hit_cnt, 32'd1);

    do_req(1, 32'h44, 32'h1234_5678, 0);
    do_req(0, 32'h144, 32'h0, 1);
    chk("lit_wb_addr_40", last_wb_addr, 32'h40);
    chk("lit_wb_word1", last_wb_data[63:32], 32'h1234_5678);
    chk("lit_fill_addr_140", last_fill_addr, 32'h140);
    chk("lit_wb_1", wb_cnt, 32'd1);
    chk("lit_miss_2", miss_cnt, 32'd2);

    do_req(1, 32'h80, 32'hDEAD_BEEF, 1);
    chk("lit_fill_addr_80", last_fill_addr, 32'h80);
    do_req(0, 32'h80, 32'h0, 0);
    chk("lit_rdata_80", last_rdata, 32'hDEAD_BEEF);
    chk("lit_hit_3", hit_cnt, 32'd3);

    do_req(1, 32'h148, 32'hCAFE_F00D, 0);
    do_req(0, 32'h44, 32'h0, 5);
    chk("lit_wb_addr_140", last_wb_addr, 32'h140);
    chk("lit_wb_word2", last_wb_data[95:64], 32'hCAFE_F00D);
    chk("lit_rdata_44_refill", last_rdata, 32'h1234_5678);
    chk("lit_wb_2", wb_cnt, 32'd2);

    req_reset_in_alloc(32'h200);
    chk("lit_hit_after_rst", hit_cnt, 32'd0);
    chk("lit_miss_after_rst", miss_cnt, 32'd0);
    do_req(0, 32'h200, 32'h0, 1);
    chk("lit_rearead_miss", miss_cnt, 32'd1);
    chk("lit_reread_hit", hit_cnt, 32'd0);
    chk("lit_rdata_200", last_rdata, 32'h1111_1111);

    rnd_mode = 1;
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      logic [2:0]  tsel;
      tsel = 3'($urandom_range(0, 4));
      a = {21'h0, tsel, 8'h0} | {24'h0, 4'($urandom_range(0, 15)), 4'h0}
          | {28'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
    end

    step();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
